adxl345_spi_responder: RTL and testbench

Synthesizable 3-wire SPI slave that emulates the register-level behaviour of the ADXL345 accelerometer. It provides the responder end of the accelerometer SPI link that the Nios accelerometer core drives: SCLK, CS_N and bidirectional SDAT in, plus the G_SENSOR_INT pin out. It serves as a sensor stand-in for bench and board bring-up. Axis samples come from a parallel sample port, so game logic can be exercised without the physical sensor.

---
 rtl/adxl345_spi_responder_if.sv | 28 ++
 rtl/adxl345_spi_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_adxl345_spi_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adxl345_spi_responder_if.sv
// SPI pad-side bundle between the accelerometer master and the ADXL345 responder.
// Carries SCLK, CS_N, the split SDAT pad and the interrupt line back to the master.
interface adxl345_spi_responder_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_sdat_in;
    logic spi_sdat_out;
    logic spi_sdat_oe;
    logic sensor_int;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_sdat_in,
        input  spi_sdat_out,
        input  spi_sdat_oe,
        input  sensor_int
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_sdat_in,
        output spi_sdat_out,
        output spi_sdat_oe,
        output sensor_int
    );
endinterface

// File: rtl/adxl345_spi_responder.sv
// 3-wire SPI (mode 3) slave emulating the ADXL345 register file.
// Axis data comes from a parallel sample port instead of a real sensor.
module adxl345_spi_responder #(
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    adxl345_spi_responder_if.slave spi,
    input  logic [15:0]            sample_x,
    input  logic [15:0]            sample_y,
    input  logic [15:0]            sample_z,
    input  logic                   sample_valid
);
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned CW = 3;

    localparam logic [AW-1:0] A_DEVID       = 6'h00;
    localparam logic [AW-1:0] A_BW_RATE     = 6'h2C;
    localparam logic [AW-1:0] A_POWER_CTL   = 6'h2D;
    localparam logic [AW-1:0] A_INT_ENABLE  = 6'h2E;
    localparam logic [AW-1:0] A_INT_SOURCE  = 6'h30;
    localparam logic [AW-1:0] A_DATA_FORMAT = 6'h31;
    localparam logic [AW-1:0] A_DATAX0      = 6'h32;
    localparam logic [AW-1:0] A_DATAX1      = 6'h33;
    localparam logic [AW-1:0] A_DATAY0      = 6'h34;
    localparam logic [AW-1:0] A_DATAY1      = 6'h35;
    localparam logic [AW-1:0] A_DATAZ0      = 6'h36;
    localparam logic [AW-1:0] A_DATAZ1      = 6'h37;

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdat_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, sdat_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CW-1:0] bit_cnt_q;
    logic [DW-2:0] shift_in_q;
    logic [DW-1:0] shift_out_q;
    logic [AW-1:0] addr_q;
    logic          mb_q;
    logic          sdat_out_q, sdat_oe_q;
    logic          rd_hit_q;

    logic [DW-1:0] bw_rate_q, power_ctl_q, int_enable_q, data_format_q;
    logic [SW-1:0] x_q, y_q, z_q;
    logic [SW-1:0] pend_x_q, pend_y_q, pend_z_q;
    logic          pend_valid_q, data_ready_q, sensor_int_q;

    logic [DW-1:0] rx_byte_c, rd_data_c;
    logic [AW-1:0] rd_addr_c;
    logic          byte_end_c, cmd_done_c, wr_done_c, rd_done_c;
    logic          strobe_c, direct_load_c, pend_load_c, dr_set_c, dr_clr_c;

    // Pin synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            sdat_sync <= '0;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], spi.spi_sdat_in};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdat_s    = sdat_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign rx_byte_c  = {shift_in_q, sdat_s};
    assign byte_end_c = sclk_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_done_c = 1'b0;
        wr_done_c  = 1'b0;
        rd_done_c  = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = CMD;
                CMD:   if (byte_end_c) begin
                           cmd_done_c = 1'b1;
                           state_d    = rx_byte_c[7] ? READ : WRITE;
                       end
                WRITE: wr_done_c = byte_end_c;
                READ:  rd_done_c = byte_end_c;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next byte to shift out: command address, or the stepped address after a data byte
    always_comb begin
        rd_addr_c = cmd_done_c ? rx_byte_c[AW-1:0] : (mb_q ? addr_q + 6'd1 : addr_q);
        rd_data_c = '0;
        case (rd_addr_c)
            A_DEVID:       rd_data_c = DEVID;
            A_BW_RATE:     rd_data_c = bw_rate_q;
            A_POWER_CTL:   rd_data_c = power_ctl_q;
            A_INT_ENABLE:  rd_data_c = int_enable_q;
            A_INT_SOURCE:  rd_data_c = {data_ready_q, 7'b0};
            A_DATA_FORMAT: rd_data_c = data_format_q;
            A_DATAX0:      rd_data_c = x_q[7:0];
            A_DATAX1:      rd_data_c = x_q[15:8];
            A_DATAY0:      rd_data_c = y_q[7:0];
            A_DATAY1:      rd_data_c = y_q[15:8];
            A_DATAZ0:      rd_data_c = z_q[7:0];
            A_DATAZ1:      rd_data_c = z_q[15:8];
            default:       rd_data_c = '0;
        endcase
    end

    // Serial datapath: shift in on SCLK rise, shift out on SCLK fall
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            mb_q        <= 1'b0;
            sdat_out_q  <= 1'b0;
            sdat_oe_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            if (cs_rise || cs_fall) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && state_q != IDLE) begin
                shift_in_q <= rx_byte_c[DW-2:0];
                bit_cnt_q  <= bit_cnt_q + 3'd1;
            end

            if (cmd_done_c) begin
                addr_q <= rx_byte_c[AW-1:0];
                mb_q   <= rx_byte_c[6];
            end else if ((wr_done_c || rd_done_c) && mb_q) begin
                addr_q <= addr_q + 6'd1;
            end

            if (cmd_done_c || rd_done_c)
                shift_out_q <= rd_data_c;
            else if (sclk_fall && state_q == READ)
                shift_out_q <= {shift_out_q[DW-2:0], 1'b0};

            if (cs_rise) begin
                sdat_oe_q  <= 1'b0;
                sdat_out_q <= 1'b0;
            end else if (sclk_fall && state_q == READ) begin
                sdat_oe_q  <= 1'b1;
                sdat_out_q <= shift_out_q[DW-1];
            end

            if (cs_rise || cs_fall)
                rd_hit_q <= 1'b0;
            else if (rd_done_c && addr_q >= A_DATAX0 && addr_q <= A_DATAZ1)
                rd_hit_q <= 1'b1;
        end
    end

    // Writable control registers; read-only and unmapped addresses drop the write
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bw_rate_q     <= 8'h0A;
            power_ctl_q   <= '0;
            int_enable_q  <= '0;
            data_format_q <= '0;
        end else if (wr_done_c) begin
            case (addr_q)
                A_BW_RATE:     bw_rate_q     <= rx_byte_c;
                A_POWER_CTL:   power_ctl_q   <= rx_byte_c;
                A_INT_ENABLE:  int_enable_q  <= rx_byte_c;
                A_DATA_FORMAT: data_format_q <= rx_byte_c;
                default: ;
            endcase
        end
    end

    // Samples arriving mid-transaction are parked so a burst never sees torn data
    assign strobe_c      = sample_valid & power_ctl_q[3];
    assign direct_load_c = strobe_c & cs_s;
    assign pend_load_c   = cs_rise & pend_valid_q;
    assign dr_set_c      = direct_load_c | pend_load_c;
    assign dr_clr_c      = cs_rise & rd_hit_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_z_q     <= '0;
            pend_valid_q <= 1'b0;
            data_ready_q <= 1'b0;
            sensor_int_q <= 1'b0;
        end else begin
            if (direct_load_c) begin
                x_q <= sample_x;
                y_q <= sample_y;
                z_q <= sample_z;
            end else if (pend_load_c) begin
                x_q <= pend_x_q;
                y_q <= pend_y_q;
                z_q <= pend_z_q;
            end

            if (strobe_c && !cs_s) begin
                pend_x_q     <= sample_x;
                pend_y_q     <= sample_y;
                pend_z_q     <= sample_z;
                pend_valid_q <= 1'b1;
            end else if (cs_rise) begin
                pend_valid_q <= 1'b0;
            end

            if (dr_set_c)      data_ready_q <= 1'b1;
            else if (dr_clr_c) data_ready_q <= 1'b0;

            sensor_int_q <= (int_enable_q[7] & data_ready_q) ^ data_format_q[5];
        end
    end

    assign spi.spi_sdat_out = sdat_out_q;
    assign spi.spi_sdat_oe  = sdat_oe_q;
    assign spi.sensor_int   = sensor_int_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Directed bench for adxl345_spi_responder: a mode-3 SPI master model driving
// register transactions from a vector table plus hand-written corner sequences.
module tb_adxl345_spi_responder;
    localparam int HALF = 8;
    localparam int NV   = 16;

    typedef struct {
        string           name;
        int              nbytes;
        bit              rd;
        logic [0:6][7:0] tx;
        logic [0:6][7:0] exp;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        sample_valid;

    adxl345_spi_responder_if bus ();

    adxl345_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_n),
        .spi           (bus),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_z      (sample_z),
        .sample_valid  (sample_valid)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_buf [7];
    logic [7:0] rx_buf [7];
    logic       oe_hi_cmd, oe_lo_data, oe_hi_data, oe_after;
    vec_t       tbl [NV];
    logic [7:0] exp_old [6];
    logic [7:0] exp_new [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic pulse_sample();
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    // One SCLK period: drive on falling edge, sample slave output at rising edge
    task automatic sbit(input logic di, output logic dout, output logic oe_s);
        bus.spi_sclk    = 1'b0;
        bus.spi_sdat_in = di;
        tick(HALF);
        bus.spi_sclk = 1'b1;
        dout = bus.spi_sdat_out;
        oe_s = bus.spi_sdat_oe;
        tick(HALF);
    endtask

    task automatic xfer(input int nbits, input int strobe_at);
        logic d, o;
        int   b, i;
        oe_hi_cmd  = 1'b0;
        oe_lo_data = 1'b0;
        oe_hi_data = 1'b0;
        for (int k = 0; k < 7; k++) rx_buf[k] = 8'h00;
        bus.spi_cs_n = 1'b0;
        tick(HALF);
        for (int k = 0; k < nbits; k++) begin
            b = k / 8;
            i = 7 - (k % 8);
            if (k == strobe_at) pulse_sample();
            sbit(tx_buf[b][i], d, o);
            rx_buf[b][i] = d;
            if (b == 0 && o) oe_hi_cmd = 1'b1;
            if (b > 0 && !o) oe_lo_data = 1'b1;
            if (b > 0 && o)  oe_hi_data = 1'b1;
        end
        bus.spi_cs_n = 1'b1;
        tick(3);
        oe_after = bus.spi_sdat_oe;
        tick(HALF);
    endtask

    task automatic rd(input logic [7:0] cmd, input int n);
        tx_buf[0] = cmd;
        for (int b = 1; b < 7; b++) tx_buf[b] = 8'h00;
        xfer(8 * (n + 1), -1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        tx_buf[0] = a;
        tx_buf[1] = d;
        for (int b = 2; b < 7; b++) tx_buf[b] = 8'h00;
        xfer(16, -1);
    endtask

    task automatic check_burst(input string nm, input logic [7:0] ev [6]);
        for (int b = 0; b < 6; b++)
            check($sformatf("%s[%0d]", nm, b), 32'(rx_buf[b+1]), 32'(ev[b]));
    endtask

    function automatic vec_t mk(input string n, input int nb, input bit r,
                                input logic [55:0] t, input logic [55:0] e);
        vec_t v;
        v.name = n; v.nbytes = nb; v.rd = r; v.tx = t; v.exp = e;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk("int_src_m0", 2, 1'b1, {8'hB0, 48'h0}, {8'h00, 8'h00, 40'h0});
        tbl[1]  = mk("devid",      2, 1'b1, {8'h80, 48'h0}, {8'h00, 8'hE5, 40'h0});
        tbl[2]  = mk("wr_pwr",     2, 1'b0, {8'h2D, 8'h08, 40'h0}, 56'h0);
        tbl[3]  = mk("rd_pwr",     2, 1'b1, {8'hAD, 48'h0}, {8'h00, 8'h08, 40'h0});
        tbl[4]  = mk("wr_devid",   2, 1'b0, {8'h00, 8'h55, 40'h0}, 56'h0);
        tbl[5]  = mk("devid_ro",   2, 1'b1, {8'h80, 48'h0}, {8'h00, 8'hE5, 40'h0});
        tbl[6]  = mk("bw_reset",   2, 1'b1, {8'hAC, 48'h0}, {8'h00, 8'h0A, 40'h0});
        tbl[7]  = mk("wr_bw",      2, 1'b0, {8'h2C, 8'h0F, 40'h0}, 56'h0);
        tbl[8]  = mk("rd_bw",      2, 1'b1, {8'hAC, 48'h0}, {8'h00, 8'h0F, 40'h0});
        tbl[9]  = mk("wrap",       3, 1'b1, {8'hFF, 48'h0}, {8'h00, 8'h00, 8'hE5, 32'h0});
        tbl[10] = mk("unimpl",     2, 1'b1, {8'h8F, 48'h0}, {8'h00, 8'h00, 40'h0});
        tbl[11] = mk("mb0_fixed",  3, 1'b1, {8'h80, 48'h0}, {8'h00, 8'hE5, 8'hE5, 32'h0});
        tbl[12] = mk("fmt_reset",  2, 1'b1, {8'hB1, 48'h0}, {8'h00, 8'h00, 40'h0});
        tbl[13] = mk("mb_write",   3, 1'b0, {8'h6C, 8'h0A, 8'h08, 32'h0}, 56'h0);
        tbl[14] = mk("mb_read",    3, 1'b1, {8'hEC, 48'h0}, {8'h00, 8'h0A, 8'h08, 32'h0});
        tbl[15] = mk("inten_rst",  2, 1'b1, {8'hAE, 48'h0}, {8'h00, 8'h00, 40'h0});

        exp_old = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
        exp_new = '{8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01};

        reset_n         = 1'b0;
        bus.spi_sclk    = 1'b1;
        bus.spi_cs_n    = 1'b1;
        bus.spi_sdat_in = 1'b0;
        sample_valid    = 1'b0;
        sample_x        = 16'h1234;
        sample_y        = 16'hFF80;
        sample_z        = 16'h0100;
        tick(3);
        check("rst_sdat_out", 32'(bus.spi_sdat_out), 32'd0);
        check("rst_sdat_oe",  32'(bus.spi_sdat_oe),  32'd0);
        check("rst_int",      32'(bus.sensor_int),   32'd0);
        reset_n = 1'b1;
        tick(5);

        // MEASURE is still 0, so this strobe must be ignored
        pulse_sample();
        tick(2);

        for (int v = 0; v < NV; v++) begin
            for (int b = 0; b < 7; b++) tx_buf[b] = tbl[v].tx[b];
            xfer(tbl[v].nbytes * 8, -1);
            if (tbl[v].rd) begin
                for (int b = 1; b < tbl[v].nbytes; b++)
                    check($sformatf("%s[%0d]", tbl[v].name, b), 32'(rx_buf[b]), 32'(tbl[v].exp[b]));
                check({tbl[v].name, "_oe"}, 32'({oe_hi_cmd, oe_lo_data, oe_after}), 32'd0);
            end else begin
                check({tbl[v].name, "_oe"}, 32'({oe_hi_cmd, oe_hi_data, oe_after}), 32'd0);
            end
        end

        // Sample capture with CS_N high, then DATA_READY set and cleared by a data read
        pulse_sample();
        rd(8'hB0, 1);
        check("int_src_set", 32'(rx_buf[1]), 32'h80);
        rd(8'hF2, 6);
        check_burst("burst", exp_old);
        rd(8'hB0, 1);
        check("int_src_clr", 32'(rx_buf[1]), 32'h00);

        // Interrupt pin latency and polarity
        wr(8'h2E, 8'h80);
        check("int_idle", 32'(bus.sensor_int), 32'd0);
        pulse_sample();
        check("int_lat1", 32'(bus.sensor_int), 32'd0);
        tick(1);
        check("int_lat2", 32'(bus.sensor_int), 32'd1);
        rd(8'hF2, 6);
        check("int_cleared", 32'(bus.sensor_int), 32'd0);
        wr(8'h31, 8'h20);
        check("int_inverted", 32'(bus.sensor_int), 32'd1);
        pulse_sample();
        tick(1);
        check("int_inv_set", 32'(bus.sensor_int), 32'd0);
        wr(8'h31, 8'h00);
        check("int_noinv", 32'(bus.sensor_int), 32'd1);

        // New sample mid-burst stays pending: old bytes now, new bytes next burst
        sample_x = 16'h7FFF;
        tx_buf[0] = 8'hF2;
        for (int b = 1; b < 7; b++) tx_buf[b] = 8'h00;
        xfer(56, 32);
        check_burst("burst_old", exp_old);
        check("int_after_pend", 32'(bus.sensor_int), 32'd1);
        rd(8'hB0, 1);
        check("dr_kept", 32'(rx_buf[1]), 32'h80);
        rd(8'hF2, 6);
        check_burst("burst_new", exp_new);
        rd(8'hB0, 1);
        check("dr_clr2", 32'(rx_buf[1]), 32'h00);

        // Write aborted after 4 data bits must not commit
        tx_buf[0] = 8'h2E;
        tx_buf[1] = 8'h00;
        xfer(12, -1);
        check("abort_wr_oe", 32'(oe_after), 32'd0);
        rd(8'hAE, 1);
        check("abort_no_write", 32'(rx_buf[1]), 32'h80);

        // Read aborted mid-byte: oe was driving, then releases within 3 cycles
        tx_buf[0] = 8'h80;
        xfer(12, -1);
        check("abort_rd_oe_on", 32'(oe_lo_data), 32'd0);
        check("abort_rd_oe_off", 32'(oe_after), 32'd0);
        rd(8'h80, 1);
        check("after_abort", 32'(rx_buf[1]), 32'hE5);

        // Reset during an active read drops oe without a clock edge
        begin
            logic d, o;
            bus.spi_cs_n = 1'b0;
            tick(HALF);
            for (int i = 7; i >= 0; i--) begin
                tx_buf[0] = 8'h80;
                sbit(tx_buf[0][i], d, o);
            end
            bus.spi_sclk = 1'b0;
            tick(HALF);
            check("oe_before_rst", 32'(bus.spi_sdat_oe), 32'd1);
            #2;
            reset_n = 1'b0;
            #1;
            check("oe_async_rst", 32'(bus.spi_sdat_oe), 32'd0);
            bus.spi_sclk = 1'b1;
            bus.spi_cs_n = 1'b1;
            tick(4);
            reset_n = 1'b1;
            tick(4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
